// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard inputs and pipeline control outputs shared between the stall sequencer and the core.
// The master modport is the sequencer; the slave modport is the pipeline that obeys it.
interface pipeline_stall_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             mem_valid;
  logic             mem_is_ldst;
  logic             dmem_ready;
  logic             branch_taken;
  logic             load_use_hazard;
  logic             pc_enable;
  logic             if_id_enable;
  logic             if_id_flush;
  logic             id_ex_enable;
  logic             id_ex_flush;
  logic             ex_mem_enable;
  logic             mem_wb_bubble;
  logic             bus_error;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    input  mem_valid, mem_is_ldst, dmem_ready, branch_taken, load_use_hazard,
    output pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
           ex_mem_enable, mem_wb_bubble, bus_error, stall_cycles, flush_count
  );

  modport slave (
    output mem_valid, mem_is_ldst, dmem_ready, branch_taken, load_use_hazard,
    input  pc_enable, if_id_enable, if_id_flush, id_ex_enable, id_ex_flush,
           ex_mem_enable, mem_wb_bubble, bus_error, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: memory wait > taken branch > load-use, with a bounded
// memory wait (registered bus_error pulse) and saturating stall/flush counters.
module pipeline_stall_ctrl #(
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_stall_ctrl_if.master ctl
);

  localparam int WC_W = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = (DMEM_TIMEOUT == 0) ? '0 : WC_W'(DMEM_TIMEOUT - 1);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             bus_error_q;
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;

  logic timeout_hit;
  logic mem_stall;
  logic branch_flush;
  logic pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, bubble;

  assign timeout_hit = (DMEM_TIMEOUT != 0) && (state_q == MEM_WAIT) &&
                       (wait_cnt_q == WC_LAST) && !ctl.dmem_ready;
  assign mem_stall   = ctl.mem_valid && ctl.mem_is_ldst && !ctl.dmem_ready && !timeout_hit;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    branch_flush = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_fl     = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_fl     = 1'b0;
    ex_mem_en    = 1'b1;
    bubble       = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (ctl.dmem_ready || timeout_hit) state_d = RUN;
        else                               wait_cnt_d = wait_cnt_q + WC_W'(1);
      end
      default: state_d = RUN;
    endcase

    // A branch seen while EX is frozen is held off; it reappears and flushes on release.
    if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      bubble    = 1'b1;
    end else if (ctl.branch_taken) begin
      if_id_fl     = 1'b1;
      id_ex_fl     = 1'b1;
      branch_flush = 1'b1;
    end else if (ctl.load_use_hazard) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      id_ex_fl = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      bus_error_q    <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_error_q <= timeout_hit;
      if (!pc_en && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      if (branch_flush && (flush_count_q != '1)) flush_count_q <= flush_count_q + CNT_W'(1);
    end
  end

  // Controls are gated by rst_n so the pipe is fully held while reset is asserted.
  assign ctl.pc_enable     = rst_n & pc_en;
  assign ctl.if_id_enable  = rst_n & if_id_en;
  assign ctl.if_id_flush   = rst_n & if_id_fl;
  assign ctl.id_ex_enable  = rst_n & id_ex_en;
  assign ctl.id_ex_flush   = rst_n & id_ex_fl;
  assign ctl.ex_mem_enable = rst_n & ex_mem_en;
  assign ctl.mem_wb_bubble = rst_n & bubble;
  assign ctl.bus_error     = bus_error_q;
  assign ctl.stall_cycles  = stall_cycles_q;
  assign ctl.flush_count   = flush_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl with a short timeout and narrow counters so the
// timeout and saturation corners are reachable in a few cycles.
module tb_pipeline_stall_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 4;

  // Packed control view: {pc_en, if_id_en, if_id_fl, id_ex_en, id_ex_fl, ex_mem_en, bubble, bus_error}
  localparam logic [7:0] IDLE = 8'b1101_0100;
  localparam logic [7:0] LU   = 8'b0001_1100;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] STL  = 8'b0000_0010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  pipeline_stall_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_stall_ctrl #(.DMEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctl   (bus.master)
  );

  always #5 clk = ~clk;

  wire [7:0] vec = {bus.pc_enable, bus.if_id_enable, bus.if_id_flush, bus.id_ex_enable,
                    bus.id_ex_flush, bus.ex_mem_enable, bus.mem_wb_bubble, bus.bus_error};

  typedef struct packed {
    logic [4:0] in;   // {mem_valid, mem_is_ldst, dmem_ready, branch_taken, load_use_hazard}
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] in);
    {bus.mem_valid, bus.mem_is_ldst, bus.dmem_ready, bus.branch_taken, bus.load_use_hazard} = in;
  endtask

  // Called at posedge+1; checks combinational controls mid-cycle, returns at next posedge+1.
  task automatic step(input string nm, input logic [4:0] in, input logic [7:0] exp);
    drive(in);
    @(negedge clk);
    chk(nm, {24'd0, vec}, {24'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(5'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_ctl", {24'd0, vec}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{5'b00000, IDLE};
    tbl[1] = '{5'b10000, IDLE};
    tbl[2] = '{5'b11100, IDLE};
    tbl[3] = '{5'b00001, LU};
    tbl[4] = '{5'b00010, BR};
    tbl[5] = '{5'b00011, BR};
    tbl[6] = '{5'b11000, STL};
    tbl[7] = '{5'b11011, STL};
    tbl[8] = '{5'b11110, BR};
    tbl[9] = '{5'b00000, IDLE};

    drive(5'b0);
    #2;
    chk("reset_ctl0", {24'd0, vec}, 32'd0);
    chk("reset_stall", 32'(bus.stall_cycles), 32'd0);
    chk("reset_flush", 32'(bus.flush_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) step("idle", 5'b00000, IDLE);
    chk("idle_stall", 32'(bus.stall_cycles), 32'd0);

    // Priority table
    for (int i = 0; i < 10; i++) step($sformatf("tbl%0d", i), tbl[i].in, tbl[i].exp);
    chk("tbl_stall", 32'(bus.stall_cycles), 32'd3);
    chk("tbl_flush", 32'(bus.flush_count), 32'd3);

    // 3-cycle memory wait
    do_reset();
    for (int i = 0; i < 3; i++) step("wait3", 5'b11000, STL);
    step("wait3_rel", 5'b11100, IDLE);
    step("wait3_after", 5'b00000, IDLE);
    chk("wait3_stall", 32'(bus.stall_cycles), 32'd3);

    // Branch during a 2-cycle stall flushes only on release
    do_reset();
    step("brst0", 5'b11010, STL);
    step("brst1", 5'b11010, STL);
    step("brst_rel", 5'b11110, BR);
    chk("brst_flush", 32'(bus.flush_count), 32'd1);
    chk("brst_stall", 32'(bus.stall_cycles), 32'd2);

    // Timeout: 4 stall cycles, release, bus_error the following cycle only
    do_reset();
    for (int i = 0; i < TMO; i++) step("tmo_wait", 5'b11000, STL);
    step("tmo_hit", 5'b11000, IDLE);
    step("tmo_berr", 5'b00000, IDLE | 8'h01);
    step("tmo_after", 5'b00000, IDLE);
    chk("tmo_stall", 32'(bus.stall_cycles), 32'd4);
    chk("tmo_flush", 32'(bus.flush_count), 32'd0);

    // Reset asserted in the middle of a wait
    do_reset();
    step("rmw0", 5'b11000, STL);
    step("rmw1", 5'b11000, STL);
    step("rmw2", 5'b11000, STL);
    rst_n = 1'b0;
    #1;
    chk("rmw_ctl", {24'd0, vec}, 32'd0);
    chk("rmw_stall", 32'(bus.stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    drive(5'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step("rmw_idle", 5'b00000, IDLE);
    chk("rmw_stall2", 32'(bus.stall_cycles), 32'd0);

    // Back-to-back stalls restart the wait counter
    do_reset();
    step("b2b0", 5'b11000, STL);
    step("b2b_rel0", 5'b11100, IDLE);
    for (int i = 0; i < 4; i++) step("b2b1", 5'b11000, STL);
    step("b2b_rel1", 5'b11100, IDLE);
    step("b2b_idle", 5'b00000, IDLE);
    chk("b2b_stall", 32'(bus.stall_cycles), 32'd5);

    // Counter saturation
    do_reset();
    for (int i = 0; i < 18; i++) step("sat_lu", 5'b00001, LU);
    chk("sat_stall", 32'(bus.stall_cycles), 32'd15);
    for (int i = 0; i < 17; i++) step("sat_br", 5'b00010, BR);
    chk("sat_flush", 32'(bus.flush_count), 32'd15);
    chk("sat_stall2", 32'(bus.stall_cycles), 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
